// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes (MIPS funct field),
// FSM states and an opcode classification helper.
package alu_seq_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SLT = 6'b101010;
   localparam logic [OP_W-1:0] OP_SLL = 6'b000000;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   // Shifts run iteratively; everything else completes in the EXEC cycle.
   function automatic logic is_shift(input logic [OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Brings one asynchronous push-button level into the clock domain and
// turns each press into a single-cycle pulse, however long it is held.
module btn_edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Two-flop synchroniser followed by a delayed copy for edge detection.
   // NOTE: non-blocking assignments make all three flops sample together,
   // forming a real shift chain rather than collapsing into one flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential switch-board ALU: operands and opcode are loaded from a shared
// switch bus by button strobes, then executed into registered result/flags.
// Shifts move one bit per cycle for a variable amount taken from B.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OPS  = 6
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_load_a,
   input  logic               i_load_b,
   input  logic               i_load_op,
   output logic [NB_DATA-1:0] o_res,
   output logic               o_carry,
   output logic               o_overflow,
   output logic               o_zero,
   output logic               o_negative,
   output logic               o_busy,
   output logic               o_done
);

   localparam int NB_SHAMT = $clog2(NB_DATA);
   localparam int MSB      = NB_DATA - 1;

   logic load_a;
   logic load_b;
   logic load_op;

   logic [NB_DATA-1:0]  a_q, b_q;
   logic [NB_OPS-1:0]   op_q;
   logic [OP_W-1:0]     op_code;

   state_e              state_q, state_d;
   logic [NB_DATA-1:0]  work_q, work_d;
   logic [NB_SHAMT-1:0] cnt_q, cnt_d;

   logic [NB_DATA-1:0]  res_q;
   logic                carry_q, ovf_q, zero_q, neg_q, done_q;

   logic [NB_DATA:0]    sum_w, diff_w;
   logic [NB_DATA-1:0]  alu_res;
   logic                alu_carry, alu_ovf;

   logic [NB_DATA-1:0]  shift_res;
   logic                shift_out;

   logic                wr_en;
   logic [NB_DATA-1:0]  wr_res;
   logic                wr_carry, wr_ovf;

   logic                busy;

   btn_edge_sync u_sync_a (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .btn_i  (i_load_a),
      .pulse_o(load_a)
   );

   btn_edge_sync u_sync_b (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .btn_i  (i_load_b),
      .pulse_o(load_b)
   );

   btn_edge_sync u_sync_op (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .btn_i  (i_load_op),
      .pulse_o(load_op)
   );

   assign busy    = (state_q != ST_IDLE);
   assign op_code = OP_W'(op_q);

   // Operand/opcode capture; presses arriving during execution are ignored.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
      end else if (!busy) begin
         if (load_a)  a_q  <= i_data;
         if (load_b)  b_q  <= i_data;
         if (load_op) op_q <= NB_OPS'(i_data);
      end
   end

   // Single-cycle operations, evaluated in NB_DATA+1 bits for carry/borrow.
   // NOTE: every output gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      sum_w     = {1'b0, a_q} + {1'b0, b_q};
      diff_w    = {1'b0, a_q} - {1'b0, b_q};
      alu_res   = diff_w[MSB:0];
      alu_carry = diff_w[NB_DATA];
      alu_ovf   = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
      case (op_code)
         OP_ADD: begin
            alu_res   = sum_w[MSB:0];
            alu_carry = sum_w[NB_DATA];
            alu_ovf   = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
         end
         OP_AND: begin alu_res = a_q & b_q;    alu_carry = 1'b0; alu_ovf = 1'b0; end
         OP_OR:  begin alu_res = a_q | b_q;    alu_carry = 1'b0; alu_ovf = 1'b0; end
         OP_XOR: begin alu_res = a_q ^ b_q;    alu_carry = 1'b0; alu_ovf = 1'b0; end
         OP_NOR: begin alu_res = ~(a_q | b_q); alu_carry = 1'b0; alu_ovf = 1'b0; end
         OP_SLT: begin
            alu_res   = {{(NB_DATA-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            alu_carry = 1'b0;
            alu_ovf   = 1'b0;
         end
         default: ; // SUB and any unrecognised code
      endcase
   end

   // One-bit shift step of the working register; shift_out is the bit lost.
   always_comb begin
      {shift_res, shift_out} = {1'b0, work_q};
      case (op_code)
         OP_SLL:  {shift_out, shift_res} = {work_q, 1'b0};
         OP_SRA:  {shift_res, shift_out} = {work_q[MSB], work_q};
         default: ; // SRL
      endcase
   end

   // FSM next state, shift bookkeeping and result write decision.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      wr_en    = 1'b0;
      wr_res   = alu_res;
      wr_carry = alu_carry;
      wr_ovf   = alu_ovf;
      case (state_q)
         ST_IDLE: begin
            if (load_op) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (is_shift(op_code)) begin
               work_d = a_q;
               cnt_d  = b_q[NB_SHAMT-1:0];
               if (b_q[NB_SHAMT-1:0] == '0) begin
                  wr_en    = 1'b1;
                  wr_res   = a_q;
                  wr_carry = 1'b0;
                  wr_ovf   = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_SHIFT;
               end
            end else begin
               wr_en   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            work_d = shift_res;
            cnt_d  = cnt_q - NB_SHAMT'(1);
            if (cnt_q == NB_SHAMT'(1)) begin
               wr_en    = 1'b1;
               wr_res   = shift_res;
               wr_carry = shift_out;
               wr_ovf   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and shift working registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
      end
   end

   // Result and flags update together on completion and hold otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= wr_en;
         if (wr_en) begin
            res_q   <= wr_res;
            carry_q <= wr_carry;
            ovf_q   <= wr_ovf;
            zero_q  <= (wr_res == '0);
            neg_q   <= wr_res[MSB];
         end
      end
   end

   assign o_res      = res_q;
   assign o_carry    = carry_q;
   assign o_overflow = ovf_q;
   assign o_zero     = zero_q;
   assign o_negative = neg_q;
   assign o_busy     = busy;
   assign o_done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, randomized operations
// against an arithmetic reference model, button/busy and reset-abort cases.
module tb_alu_seq;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] i_data;
   logic         i_load_a, i_load_b, i_load_op;
   logic [N-1:0] o_res;
   logic         o_carry, o_overflow, o_zero, o_negative, o_busy, o_done;

   int errors = 0;
   int checks = 0;

   logic [N-1:0] a_m, b_m;

   alu_seq #(.NB_DATA(N), .NB_OPS(6)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_data    (i_data),
      .i_load_a  (i_load_a),
      .i_load_b  (i_load_b),
      .i_load_op (i_load_op),
      .o_res     (o_res),
      .o_carry   (o_carry),
      .o_overflow(o_overflow),
      .o_zero    (o_zero),
      .o_negative(o_negative),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: result, carry, overflow and shift latency from plain arithmetic.
   function automatic void model(input logic [5:0] op, input logic [N-1:0] a, b,
                                 output logic [N-1:0] r, output logic c, v,
                                 output int lat);
      int sa, sb, s, amt;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      amt = int'(b) % N;
      c   = 1'b0;
      v   = 1'b0;
      lat = 0;
      case (op)
         6'h20: begin
            s = int'(a) + int'(b);
            r = s[N-1:0];
            c = (s > 255);
            v = (sa + sb > 127) || (sa + sb < -128);
         end
         6'h24: r = a & b;
         6'h25: r = a | b;
         6'h26: r = a ^ b;
         6'h27: r = ~(a | b);
         6'h2A: r = (sa < sb) ? 8'd1 : 8'd0;
         6'h00: begin
            lat = amt;
            r   = a << amt;
            c   = (amt == 0) ? 1'b0 : a[N-amt];
         end
         6'h02: begin
            lat = amt;
            r   = a >> amt;
            c   = (amt == 0) ? 1'b0 : a[amt-1];
         end
         6'h03: begin
            lat = amt;
            r   = N'($signed(a) >>> amt);
            c   = (amt == 0) ? 1'b0 : a[amt-1];
         end
         default: begin
            s = int'(a) - int'(b);
            r = s[N-1:0];
            c = (a < b);
            v = (sa - sb > 127) || (sa - sb < -128);
         end
      endcase
   endfunction

   task automatic press(input bit is_b, input logic [N-1:0] d);
      @(negedge clk);
      i_data = d;
      if (is_b) i_load_b = 1'b1; else i_load_a = 1'b1;
      repeat (4) @(negedge clk);
      i_load_a = 1'b0;
      i_load_b = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic load_ab(input logic [N-1:0] a, input logic [N-1:0] b);
      press(1'b0, a);
      a_m = a;
      press(1'b1, b);
      b_m = b;
   endtask

   // Press the op button, then watch busy/done until completion (bounded).
   // With disturb set, i_load_a is pressed while the op is still running.
   task automatic exec_op(input string tag, input logic [5:0] op, input bit disturb);
      logic [N-1:0] r;
      logic         c, v;
      int           lat, done_idx, busy_cnt, done_cnt;
      model(op, a_m, b_m, r, c, v, lat);
      @(negedge clk);
      i_data    = N'(op);
      i_load_op = 1'b1;
      repeat (3) @(posedge clk);
      done_idx = -1;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) i_load_op = 1'b0;
         if (disturb && i == 1) begin i_data = 8'hEE; i_load_a = 1'b1; end
         if (disturb && i == 5) i_load_a = 1'b0;
         if (o_busy) busy_cnt++;
         if (o_done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
         if (done_idx >= 0 && i > done_idx + 2) break;
      end
      check({tag, " done_latency"}, done_idx, lat + 1);
      check({tag, " busy_cycles"}, busy_cnt, lat + 1);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " res"}, o_res, r);
      check({tag, " carry"}, o_carry, c);
      check({tag, " overflow"}, o_overflow, v);
      check({tag, " zero"}, o_zero, (r == 0));
      check({tag, " negative"}, o_negative, r[N-1]);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " res"}, o_res, 0);
      check({tag, " flags"}, {o_carry, o_overflow, o_zero, o_negative}, 0);
      check({tag, " busy"}, o_busy, 0);
      check({tag, " done"}, o_done, 0);
   endtask

   logic [5:0] op_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

   initial begin
      logic [5:0] op;
      int         done_seen;

      rst_n     = 1'b1;
      i_data    = '0;
      i_load_a  = 1'b0;
      i_load_b  = 1'b0;
      i_load_op = 1'b0;
      a_m       = '0;
      b_m       = '0;
      #3 rst_n = 1'b0;
      #10;
      check_idle_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed cases.
      load_ab(8'h7F, 8'h01); exec_op("add_ovf",   6'h20, 1'b0);
      load_ab(8'hFF, 8'h01); exec_op("add_carry", 6'h20, 1'b0);
      load_ab(8'h05, 8'h07); exec_op("sub_borrow",6'h22, 1'b0);
      load_ab(8'h90, 8'h03); exec_op("sra3",      6'h03, 1'b0);
      load_ab(8'h81, 8'h01); exec_op("srl1",      6'h02, 1'b0);
      load_ab(8'h5A, 8'h00); exec_op("sll0",      6'h00, 1'b0);
      load_ab(8'h01, 8'h07); exec_op("sll7",      6'h00, 1'b0);
      load_ab(8'hFE, 8'h01); exec_op("slt_neg",   6'h2A, 1'b0);
      load_ab(8'h09, 8'h04); exec_op("unknown",   6'h3F, 1'b0);

      // Randomized operations against the model.
      for (int k = 0; k < 24; k++) begin
         int sel;
         sel = $urandom_range(0, 10);
         op  = (sel == 10) ? 6'($urandom) : op_tab[sel];
         load_ab(8'($urandom), 8'($urandom));
         exec_op($sformatf("rand%0d_op%02h", k, op), op, 1'b0);
      end

      // Button held for 50 cycles while the switch bus changes: one capture.
      @(negedge clk);
      i_data   = 8'h3C;
      i_load_a = 1'b1;
      repeat (10) @(negedge clk);
      i_data = 8'hA5;
      repeat (40) @(negedge clk);
      i_load_a = 1'b0;
      repeat (2) @(negedge clk);
      a_m = 8'h3C;
      press(1'b1, 8'h01);
      b_m = 8'h01;
      exec_op("held_btn", 6'h20, 1'b0);

      // A load pressed during a 7-bit shift is dropped.
      load_ab(8'h11, 8'h07);
      exec_op("sll7_busy", 6'h00, 1'b1);
      exec_op("after_busy_load", 6'h20, 1'b0);

      // Reset in the middle of a shift aborts at once, with no done pulse.
      load_ab(8'hFF, 8'h07);
      @(negedge clk);
      i_data    = 8'h00;
      i_load_op = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_load_op = 1'b0;
      repeat (2) @(negedge clk);
      check("shift_running busy", o_busy, 1);
      rst_n = 1'b0;
      #1;
      check_idle_zero("rst_abort");
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (o_done || o_busy) done_seen++;
      end
      rst_n = 1'b1;
      a_m = '0;
      b_m = '0;
      repeat (12) begin
         @(negedge clk);
         if (o_done || o_busy) done_seen++;
      end
      check("rst_abort no_activity", done_seen, 0);
      check_idle_zero("after_release");
      load_ab(8'h03, 8'h04);
      exec_op("post_reset_add", 6'h20, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Clocked, parametrised successor to the combinational switch-board ALU: operands and opcode are loaded from one shared switch bus via three push-button strobes, then executed by a small FSM into a registered result with status flags. Buttons are synchronised and edge-detected internally, so no signal is used as a clock. Shifts take a variable amount and run iteratively, one bit per cycle. The block sits between the board switch/button inputs and the LED/display outputs.

## Interface
- NB_DATA, 8, operand/result width (≥4, power of two)
- NB_OPS, 6, opcode width (MIPS funct encoding)
- NB_SHAMT, $clog2(NB_DATA), derived shift-amount width (localparam)
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_data  in  NB_DATA  shared switch bus: operand or opcode (low NB_OPS bits)
- i_load_a / i_load_b / i_load_op  in  1 each  raw button levels, asynchronous to i_clk
- o_res  out  NB_DATA  registered result
- o_carry, o_overflow, o_zero, o_negative  out  1 each  registered flags
- o_busy  out  1  execution in progress
- o_done  out  1  one-cycle pulse when o_res/flags update

## Operation
- Each button: 2-flop sync, then rising-edge detect → one-cycle load pulse per press; held button gives exactly one pulse.
- Load pulse A/B: register ← i_data. Op pulse: op ← i_data[NB_OPS-1:0] and execution starts.
- Load pulses (any) while o_busy=1 are dropped. Simultaneous A/B/op pulses all capture the same i_data; execution uses the newly captured values.
- FSM IDLE → EXEC (1 cycle) → SHIFT (shifts only) → IDLE. EXEC: single-cycle ops write result; shifts load work=A, cnt=B[NB_SHAMT-1:0]; if cnt=0 write A immediately. SHIFT: one bit per cycle, cnt−1; write result when cnt reaches 0.
- Ops: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 (signed A<B → 1 else 0), SLL 000000, SRL 000010, SRA 000011. Any other code executes SUB.
- Arithmetic in NB_DATA+1 bits. ADD: carry = unsigned carry-out, overflow = signed overflow. SUB: carry = borrow (A<B unsigned), overflow = signed overflow. Shifts: carry = last bit shifted out (0 if amount 0), overflow=0. Logic/SLT: carry=overflow=0.
- zero = (o_res==0); negative = o_res[NB_DATA-1]; all flags written together with o_res.
- o_res/flags hold until next completion.

## Timing
- Reset (async assert, sync release): o_res=0, all flags 0, o_busy=0, o_done=0, A=B=op=0, FSM IDLE, sync flops 0.
- Button rises before edge k → load pulse during cycle k+1..k+2 → register captures at edge k+2; i_data must be stable at that edge.
- Op captured at edge t: o_busy=1 from t; single-cycle op: result written at t+1, o_done=1 for cycle t+1..t+2, o_busy=0 from t+1.
- Shift by n: result at t+1+n, o_busy high t..t+1+n, latency 1+n cycles (max NB_DATA).
- Reset mid-execution aborts immediately; no o_done.

## Structure
- Package alu_seq_pkg: opcode localparams, FSM state enum, op-class helper (is_shift).
- Sub-module btn_edge_sync (2-flop sync + edge detect, 1-bit), instantiated three times.
- Datapath and FSM in alu_seq.

## Test plan
- ADD A=0x7F B=0x01 → o_res=0x80, overflow=1, carry=0, negative=1, o_done one cycle after op capture.
- ADD A=0xFF B=0x01 → 0x00, carry=1, zero=1, overflow=0; SUB A=0x05 B=0x07 → 0xFE, carry=1, negative=1.
- SRA A=0x90 B=3 → 0xF2, carry=0, o_busy high 4 cycles; SRL A=0x81 B=1 → 0x40, carry=1; SLL B=0 → A in 1 cycle.
- SLT A=0xFE B=0x01 → 0x01; unknown op 0x3F with A=9 B=4 → 0x05.
- Held button for 50 cycles → exactly one capture; i_load_a pressed during SLL by 7 → A unchanged.
- SLL A=0xFF B=7, drive i_rst_n low 3 cycles into SHIFT → all outputs 0 immediately, no o_done, FSM IDLE after release.
